// File: rtl/uart_pkg.sv
// Shared UART definitions for the board-to-board link, used by both the
// transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_result_tx_if.sv
// Request/line bundle between the adder side and the UART result transmitter.
interface uart_result_tx_if;
  logic        start;
  logic [31:0] data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, output data, input tx, input busy, input done);
  modport slave  (input start, input data, output tx, output busy, output done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, emits a one-cycle tick on the
// last count and restarts from 0 whenever clr_i is asserted.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: wrap on tick, restart on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_result_tx.sv
// Serialises the 32-bit adder result as NBYTES back-to-back 8N1 frames,
// least significant byte first, on a single glitch-free line.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int NBYTES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_result_tx_if.slave  txif
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [1:0] LAST_BYTE    = 2'(NBYTES - 1);
  localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick_s;
  logic        clr_s;

  // Restarting the bit timer on every state change keeps byte timing from drifting.
  assign clr_s = (state_q == S_IDLE) || (state_d != state_q);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr_s),
    .tick_o (tick_s)
  );

  // Frame sequencing; tx_d is the value the line takes at the next edge.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (txif.start) begin
          state_d    = S_START;
          shreg_d    = txif.data;
          bit_idx_d  = 3'd0;
          byte_idx_d = 2'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tick_s) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; the line resets to its idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= 32'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txif.tx   = tx_q;
  assign txif.busy = busy_q;
  assign txif.done = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: two instances (4 bytes @16 clk/bit, 1 byte @2 clk/bit)
// decoded by a behavioural UART receiver and scored against expected-byte queues.
module tb_uart_result_tx;
  import uart_pkg::*;

  localparam int CPB0 = 16;
  localparam int CPB1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  uart_result_tx_if bus0 ();
  uart_result_tx_if bus1 ();

  uart_result_tx #(.CLK_HZ(160), .BAUD(10), .NBYTES(4)) dut0 (.clk(clk), .rst_n(rst_n), .txif(bus0));
  uart_result_tx #(.CLK_HZ(20),  .BAUD(10), .NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .txif(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int c);
    return (c == 0) ? bus0.tx : bus1.tx;
  endfunction
  function automatic logic get_busy(input int c);
    return (c == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic get_done(input int c);
    return (c == 0) ? bus0.done : bus1.done;
  endfunction

  task automatic drive(input int c, input logic s, input logic [31:0] d);
    if (c == 0) begin
      bus0.start = s;
      bus0.data  = d;
    end else begin
      bus1.start = s;
      bus1.data  = d;
    end
  endtask

  // Reference model: a word becomes its low NBYTES bytes, lowest first.
  task automatic issue(input int c, input logic [31:0] d);
    drive(c, 1'b1, d);
    if (c == 0) begin
      for (int i = 0; i < 4; i++) exp_q0.push_back(d[8*i +: 8]);
    end else begin
      exp_q1.push_back(d[7:0]);
    end
  endtask

  task automatic score(input int c, input logic [7:0] got, input logic stop);
    logic [7:0] e;
    check($sformatf("ch%0d_stop_bit", c), 32'(stop), 32'd1);
    if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL ch%0d_extra_frame: got byte %02h, expected no frame", c, got);
    end else begin
      if (c == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("ch%0d_byte", c), 32'(got), 32'(e));
    end
  endtask

  // Monitor: sample each frame mid-bit; abandon any frame cut by reset.
  initial begin
    logic       rx_act[2];
    int         rx_cnt[2];
    logic [7:0] rx_sh[2];
    int         cpb;
    int         j;
    logic       ln;
    rx_act[0] = 1'b0;
    rx_act[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        cpb = (c == 0) ? CPB0 : CPB1;
        ln  = get_tx(c);
        if (rst_n !== 1'b1) begin
          rx_act[c] = 1'b0;
        end else if (!rx_act[c]) begin
          if (ln == 1'b0) begin
            rx_act[c] = 1'b1;
            rx_cnt[c] = 0;
          end
        end else begin
          rx_cnt[c]++;
          if (rx_cnt[c] % cpb == cpb / 2) begin
            j = rx_cnt[c] / cpb;
            if (j == 0) begin
              check($sformatf("ch%0d_start_bit", c), 32'(ln), 32'd0);
            end else if (j <= DATA_BITS) begin
              rx_sh[c][j-1] = ln;
            end else begin
              score(c, rx_sh[c], ln);
              rx_act[c] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Follows one transaction from its issue cycle (0) to the done pulse.
  task automatic track(input int c, input int inj, output int busy_cnt,
                       output int done_cyc, output logic tx1);
    int k;
    busy_cnt = 0;
    done_cyc = -1;
    tx1      = 1'bx;
    k        = 0;
    while (done_cyc < 0 && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        drive(c, 1'b0, $urandom());
        tx1 = get_tx(c);
      end
      if (inj > 0 && k == inj)     drive(c, 1'b1, 32'hFFFF_FFFF);
      if (inj > 0 && k == inj + 1) drive(c, 1'b0, 32'hFFFF_FFFF);
      if (get_busy(c)) busy_cnt++;
      if (get_done(c)) done_cyc = k;
    end
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL ch%0d_timeout: got no done pulse, expected one within 2000 cycles", c);
    end
  endtask

  task automatic txn(input int c, input logic [31:0] d, input int inj, input string tag);
    int   bc;
    int   dc;
    logic t1;
    int   expb;
    expb = (c == 0) ? FRAME_BITS * 4 * CPB0 : FRAME_BITS * 1 * CPB1;
    issue(c, d);
    track(c, inj, bc, dc, t1);
    check({tag, "_busy_len"},   32'(bc), 32'(expb));
    check({tag, "_done_cycle"}, 32'(dc), 32'(expb + 1));
    check({tag, "_tx_fall"},    32'(t1), 32'd0);
  endtask

  task automatic idle_window(input int n, input string tag);
    int err;
    err = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 ||
          bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) err++;
    end
    check(tag, 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0);
    drive(1, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(bus0.tx),   32'd1);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    rst_n = 1'b1;
    idle_window(100, "idle_after_reset");

    txn(0, 32'h1234_A55A, 0, "single_word");
    idle_window(5, "single_done_once");

    txn(0, 32'h0000_0000, 100, "ignored_start");
    idle_window(50, "ignored_not_queued");

    txn(0, $urandom(), 0, "b2b_first");
    txn(0, 32'h0000_00C3, 0, "b2b_second");
    for (int i = 0; i < 3; i++) txn(0, $urandom(), 0, $sformatf("rand%0d", i));
    idle_window(5, "idle_after_rand");

    txn(1, 32'hDEAD_BE81, 0, "nb1");
    for (int i = 0; i < 5; i++) txn(1, $urandom(), 0, $sformatf("nb1_rand%0d", i));
    idle_window(5, "idle_after_nb1");

    d = $urandom() & 32'hFFFF_F7FF;
    issue(0, d);
    @(negedge clk);
    drive(0, 1'b0, d);
    repeat (229) @(negedge clk);
    check("pre_rst_tx_low", 32'(bus0.tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx",   32'(bus0.tx),   32'd1);
    check("async_rst_busy", 32'(bus0.busy), 32'd0);
    exp_q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(bus0.busy), 32'd0);
    txn(0, $urandom(), 0, "post_rst_word");
    idle_window(20, "final_idle");

    check("leftover_q0", 32'(exp_q0.size()), 32'd0);
    check("leftover_q1", 32'(exp_q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
